// File: rtl/spine_router_xbar.sv
// Spine router crossbar: per-input FIFOs, per-output round-robin arbiters and
// registered valid/ready output stages, with a saturating drop counter.
module spine_router_xbar #(
    parameter int GROUP_ID   = 2,
    parameter int NUM_LEAF   = 4,
    parameter int NUM_GROUPS = 8,
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_CNT_W = 8,
    localparam int NUM_PORTS = NUM_LEAF + NUM_GROUPS - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*DWIDTH-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [NUM_PORTS*DWIDTH-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic [NUM_PORTS-1:0]          out_ready,
    input  logic [NUM_PORTS-1:0]          out_enable,
    output logic [DROP_CNT_W-1:0]         drop_count
);

    localparam int LEAF_W = $clog2(NUM_LEAF);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int EXT_W  = DROP_CNT_W + PORT_W + 1;

    localparam logic [PTR_W:0]      FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [3:0]          GID       = 4'(GROUP_ID);
    localparam logic [4:0]          NGRP      = 5'(NUM_GROUPS);
    localparam logic [PORT_W-1:0]   LEAF_BASE = PORT_W'(NUM_LEAF);
    localparam logic [PORT_W-1:0]   LAST_PORT = PORT_W'(NUM_PORTS - 1);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

    logic [NUM_PORTS-1:0][DWIDTH-1:0]    head;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_row;    // [input][output]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant_row;  // [output][input]
    logic [NUM_PORTS-1:0]                drop_vec;
    logic [NUM_PORTS-1:0]                pop_vec;

    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
    logic [EXT_W-1:0]      drop_sum;

    // ---------------- input FIFOs and route decode ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
            logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_q;
            logic [PTR_W-1:0]  rd_ptr_q;
            logic [PTR_W:0]    count_q;
            logic              push;
            logic              nonempty;
            logic              routable;
            logic [3:0]        dest_group;
            logic [LEAF_W-1:0] dest_leaf;
            logic [PORT_W-1:0] route;

            // Ready comes only from registered occupancy, so a full FIFO
            // being popped this cycle still refuses a new flit.
            assign in_ready[gi] = (count_q != FULL_CNT);
            assign push         = in_valid[gi] & in_ready[gi];
            assign nonempty     = (count_q != '0);
            assign head[gi]     = mem_q[rd_ptr_q];

            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_data[gi*DWIDTH +: DWIDTH];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (pop_vec[gi]) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                    if (push && !pop_vec[gi]) begin
                        count_q <= count_q + 1'b1;
                    end else if (!push && pop_vec[gi]) begin
                        count_q <= count_q - 1'b1;
                    end
                end
            end

            assign dest_group = head[gi][DWIDTH-1 -: 4];
            assign dest_leaf  = head[gi][DWIDTH-5 -: LEAF_W];

            // Remote slots skip our own group number.
            always_comb begin
                route    = '0;
                routable = 1'b1;
                if (dest_group == GID) begin
                    route = PORT_W'(dest_leaf);
                end else if (dest_group < GID) begin
                    route = LEAF_BASE + PORT_W'(dest_group);
                end else if ({1'b0, dest_group} < NGRP) begin
                    route = LEAF_BASE + PORT_W'(dest_group) - 1'b1;
                end else begin
                    routable = 1'b0;
                end
            end

            assign drop_vec[gi] = nonempty & ~routable;
            assign req_row[gi]  = (nonempty && routable) ? (NUM_PORTS'(1) << route) : '0;
        end
    endgenerate

    // A head targets one output only, so OR-ing grant columns is a clean pop.
    always_comb begin
        pop_vec = drop_vec;
        for (int o = 0; o < NUM_PORTS; o++) begin
            pop_vec = pop_vec | grant_row[o];
        end
    end

    // ---------------- per-output arbiters and output stages ----------------
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            logic [PORT_W-1:0] rr_q;
            logic [PORT_W-1:0] rr_d;
            logic [PORT_W-1:0] grant_idx;
            logic              grant;
            logic              loadable;
            logic [DWIDTH-1:0] data_q;
            logic              valid_q;

            assign loadable = ~valid_q | out_ready[gi];

            always_comb begin : arb
                int idx;
                idx       = 0;
                grant     = 1'b0;
                grant_idx = '0;
                if (out_enable[gi] && loadable) begin
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        idx = int'(rr_q) + k;
                        if (idx >= NUM_PORTS) begin
                            idx = idx - NUM_PORTS;
                        end
                        if (!grant && req_row[idx][gi]) begin
                            grant     = 1'b1;
                            grant_idx = PORT_W'(idx);
                        end
                    end
                end
            end

            assign rr_d          = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
            assign grant_row[gi] = grant ? (NUM_PORTS'(1) << grant_idx) : '0;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rr_q    <= '0;
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (grant) begin
                    data_q  <= head[grant_idx];
                    valid_q <= 1'b1;
                    rr_q    <= rr_d;
                end else if (out_ready[gi]) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_valid[gi]                 = valid_q;
            assign out_data[gi*DWIDTH +: DWIDTH] = data_q;
        end
    endgenerate

    // ---------------- saturating drop counter ----------------
    always_comb begin
        drop_sum     = EXT_W'(drop_count_q) + EXT_W'($countones(drop_vec));
        drop_count_d = drop_sum[DROP_CNT_W-1:0];
        if (drop_sum > EXT_W'(DROP_MAX)) begin
            drop_count_d = DROP_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;

endmodule
